mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the maximum number of consecutive data grants while an instruction request waits.
REQ-002 SHALL have port CLK  input  1  system clock, rising edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port iREN  input  1  icache read request.
REQ-005 SHALL have port iaddr  input  32  icache word address.
REQ-006 SHALL have port iload  output  32  instruction read data.
REQ-007 SHALL have port iwait  output  1  icache stall; low for exactly the completing cycle.
REQ-008 SHALL have port dREN / dWEN  input  1 each  dcache read / write request.
REQ-009 SHALL have port daddr / dstore  input  32 each  dcache address / write data.
REQ-010 SHALL have port dload  output  32  data read data.
REQ-011 SHALL have port dwait  output  1  dcache stall; low for exactly the completing cycle.
REQ-012 SHALL have port ramREN / ramWEN  output  1 each  RAM read / write strobe.
REQ-013 SHALL have port ramaddr / ramstore  output  32 each  RAM address / write data.
REQ-014 SHALL have port ramload  input  32  RAM read data.
REQ-015 SHALL have port ramstate  input  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
REQ-016 SHALL have port bus_err  output  1  sticky flag, set on any ERROR.

Function
REQ-017 SHALL implement the FSM states IDLE, IGNT and DGNT.
REQ-018 In IDLE: SHALL drive all RAM strobes low and iwait = dwait = 1 whenever the corresponding request is high.
REQ-019 IDLE -> DGNT when (dREN|dWEN) and (starve_cnt < STARVE_LIMIT or !iREN); else IDLE -> IGNT when iREN; else remain in IDLE.
REQ-020 In IGNT: ramREN=1, ramaddr=iaddr, iload=ramload; iwait=0 only when ramstate==ACCESS.
REQ-021 In DGNT: ramaddr=daddr and ramstore=dstore; dWEN has priority (ramWEN=1, ramREN=0), otherwise ramREN=1 and dload=ramload; dwait=0 only when ramstate==ACCESS.
REQ-022 A grant SHALL return to IDLE on the cycle after ramstate==ACCESS, so a transfer costs at least 2 cycles.
REQ-023 If the granted request drops before ACCESS, SHALL abort to IDLE on the next edge, deassert strobes in that cycle, and not complete.
REQ-024 On ramstate==ERROR in a grant: SHALL set bus_err, keep wait high, and return to IDLE so the requester retries.
REQ-025 starve_cnt (width clog2(STARVE_LIMIT+1)): +1 on each IDLE->DGNT with iREN high, saturating; cleared on IDLE->IGNT or any cycle iREN is low.
REQ-026 The non-granted requester's wait SHALL remain 1 throughout; its load output SHALL be 0.
REQ-027 Simultaneous dREN and dWEN SHALL be treated as a write.

Reset
REQ-028 On nRST low: state=IDLE, starve_cnt=0, bus_err=0; all RAM strobes, ramaddr, ramstore, iload and dload = 0.
REQ-029 Reset mid-grant SHALL abandon the transfer immediately, with no completion pulse after release.

Structure
REQ-030 ramstate_t and word_t SHALL come from cpu_types_pkg; the arbiter state enum SHALL be added there as arbstate_t.
REQ-031 SHALL contain one registered FSM plus the counter; no sub-module is required.

Verification
REQ-032 iREN=1, iaddr=0x40, RAM gives ACCESS after 2 BUSY cycles with ramload=0x8C220004 -> IGNT for 3 cycles, iwait low in cycle 3 only, iload=0x8C220004.
REQ-033 iREN and dREN asserted together, starve_cnt=0 -> DGNT first, then IGNT; starve_cnt=1 then 0.
REQ-034 dWEN held with back-to-back stores while iREN=1 and STARVE_LIMIT=4 -> 4 data grants, then 1 instruction grant, then data grants resume.
REQ-035 dWEN=1, dREN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF, dwait low on ACCESS.
REQ-036 ramstate=ERROR during IGNT -> bus_err=1 sticky, iwait stays 1, return to IDLE, re-grant IGNT.
REQ-037 nRST pulsed low mid-DGNT, or dREN dropped before ACCESS -> IDLE next edge, strobes low, no dwait-low pulse.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Types shared by the CPU memory side: the RAM handshake state, the data word
// and the memory arbiter state.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arbstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between icache and dcache: data wins unless an
// instruction fetch has been passed over STARVE_LIMIT times in a row.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        bus_err
);

  localparam int unsigned         CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(STARVE_LIMIT);

  arbstate_t        state, state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  logic             bus_err_nxt;
  ramstate_t        rs;
  logic             d_req;
  logic             ram_done;
  logic             ram_err;

  assign rs       = ramstate_t'(ramstate);
  assign d_req    = dREN | dWEN;
  assign ram_done = (rs == ACCESS);
  assign ram_err  = (rs == ERROR);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      bus_err    <= bus_err_nxt;
    end
  end

  // Grant selection, grant exit (done, error or dropped request) and starvation count.
  always_comb begin
    state_nxt   = state;
    starve_nxt  = starve_cnt;
    bus_err_nxt = bus_err;
    case (state)
      IDLE: begin
        if (d_req && ((starve_cnt < CNT_MAX) || !iREN)) begin
          state_nxt = DGNT;
          if (iREN && (starve_cnt != CNT_MAX)) starve_nxt = starve_cnt + CNT_W'(1);
        end else if (iREN) begin
          state_nxt  = IGNT;
          starve_nxt = '0;
        end
      end
      IGNT:    if (!iREN || ram_done || ram_err) state_nxt = IDLE;
      DGNT:    if (!d_req || ram_done || ram_err) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if ((state != IDLE) && ram_err) bus_err_nxt = 1'b1;
    if (!iREN) starve_nxt = '0;
  end

  // RAM strobes follow the live request so a dropped request releases the bus at once.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state)
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iload   = ramload;
        iwait   = !(iREN && ram_done);
      end
      DGNT: begin
        ramWEN   = dWEN;
        ramREN   = dREN && !dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dWEN) dload = ramload;
        dwait    = !(d_req && ram_done);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural RAM, reference memory and
// directed plus randomized icache/dcache traffic.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned LIMIT  = 4;
  localparam int          BUDGET = 60;

  typedef struct packed {
    logic  wr;
    word_t addr;
    word_t data;
  } txn_t;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN, bus_err;
  logic [1:0]  ramstate = 2'(FREE);

  int checks = 0;
  int errors = 0;

  word_t ram_mem [word_t];
  word_t ref_mem [word_t];
  txn_t  iq[$];
  txn_t  dq[$];
  int    comp_log[$];

  int busy_cnt = 0, lat = 0, fixed_lat = -1, err_pct = 0;
  bit err_this = 1'b0, force_err = 1'b0, exp_bus_err = 1'b0;
  int d_since_i = 0, exp_run = -1;

  always #5 CLK = ~CLK;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .bus_err(bus_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic word_t init_word(input word_t a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic word_t ram_rd(input word_t a);
    if (ram_mem.exists(a)) return ram_mem[a];
    return init_word(a);
  endfunction

  function automatic word_t ref_rd(input word_t a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  // Behavioural RAM: BUSY for lat cycles of a grant, then ACCESS (or ERROR).
  initial forever begin
    @(negedge CLK);
    #1;
    if (ramREN || ramWEN) begin
      if (busy_cnt == 0) begin
        lat      = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        err_this = force_err || ((err_pct > 0) && (int'($urandom_range(0, 99)) < err_pct));
        force_err = 1'b0;
      end
      ramload = $urandom;
      if (busy_cnt < lat) begin
        ramstate = 2'(BUSY);
      end else if (err_this) begin
        ramstate    = 2'(ERROR);
        exp_bus_err = 1'b1;
      end else begin
        ramstate = 2'(ACCESS);
        if (ramWEN) ram_mem[ramaddr] = ramstore;
        else        ramload = ram_rd(ramaddr);
      end
      busy_cnt++;
    end else begin
      busy_cnt = 0;
      ramstate = 2'(FREE);
      ramload  = $urandom;
    end
  end

  // Monitor: every completion pops the oldest expectation for that side.
  initial begin : monitor
    txn_t t;
    forever begin
      @(negedge CLK);
      #2;
      if (nRST) begin
        if (!iwait) begin
          if (iq.size() == 0) check("iwait_unexpected", 32'(iwait), 32'd1);
          else begin
            t = iq.pop_front();
            check("iload", iload, t.data);
            check("i_ramaddr", ramaddr, t.addr);
            check("i_dwait_held", 32'(dwait), 32'd1);
            check("i_dload_zero", dload, 32'd0);
            check("i_bus_err", 32'(bus_err), 32'(exp_bus_err));
            if (exp_run >= 0) check("d_run_before_i", 32'(d_since_i), 32'(exp_run));
            else              check("starve_bound", 32'(d_since_i > int'(LIMIT) + 1), 32'd0);
            d_since_i = 0;
            comp_log.push_back(0);
          end
        end
        if (!dwait) begin
          if (dq.size() == 0) check("dwait_unexpected", 32'(dwait), 32'd1);
          else begin
            t = dq.pop_front();
            check("d_ramaddr", ramaddr, t.addr);
            if (t.wr) begin
              check("d_ramWEN", 32'(ramWEN), 32'd1);
              check("d_ramREN_on_write", 32'(ramREN), 32'd0);
              check("d_ramstore", ramstore, t.data);
            end else begin
              check("dload", dload, t.data);
              check("d_ramREN", 32'(ramREN), 32'd1);
            end
            check("d_iwait_held", 32'(iwait), 32'd1);
            check("d_iload_zero", iload, 32'd0);
            check("d_bus_err", 32'(bus_err), 32'(exp_bus_err));
            if (iREN) d_since_i++;
            comp_log.push_back(1);
          end
        end
      end
    end
  end

  task automatic i_start(input word_t a);
    txn_t t;
    t.wr = 1'b0; t.addr = a; t.data = ref_rd(a);
    iaddr = a;
    iREN  = 1'b1;
    iq.push_back(t);
  endtask

  task automatic d_start(input bit wr, input word_t a, input word_t v);
    txn_t t;
    t.wr = wr; t.addr = a;
    if (wr) begin
      t.data = v; ref_mem[a] = v;
      dstore = v; dWEN = 1'b1; dREN = 1'($urandom_range(0, 1));
    end else begin
      t.data = ref_rd(a);
      dstore = $urandom; dWEN = 1'b0; dREN = 1'b1;
    end
    daddr = a;
    dq.push_back(t);
  endtask

  task automatic wait_i_done(input string name);
    int k = 0;
    while (iq.size() != 0 && k < BUDGET) begin @(negedge CLK); k++; end
    check(name, 32'(iq.size()), 32'd0);
    iq.delete();
  endtask

  task automatic wait_d_done(input string name);
    int k = 0;
    while (dq.size() != 0 && k < BUDGET) begin @(negedge CLK); k++; end
    check(name, 32'(dq.size()), 32'd0);
    dq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int g, low_at, first, second;
    // Reset holds everything low even with both requests pending.
    iREN = 1'b1; dWEN = 1'b1; dREN = 1'b1;
    iaddr = 32'h44; daddr = 32'h104; dstore = 32'h1234_5678;
    repeat (3) @(negedge CLK);
    #3;
    check("rst_ramREN", 32'(ramREN), 32'd0);
    check("rst_ramWEN", 32'(ramWEN), 32'd0);
    check("rst_ramaddr", ramaddr, 32'd0);
    check("rst_ramstore", ramstore, 32'd0);
    check("rst_iload", iload, 32'd0);
    check("rst_dload", dload, 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    @(negedge CLK);
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    nRST = 1'b1;
    @(negedge CLK);

    // Single fetch: two BUSY cycles then ACCESS.
    fixed_lat = 2;
    ram_mem[32'h40] = 32'h8C22_0004;
    ref_mem[32'h40] = 32'h8C22_0004;
    i_start(32'h40);
    g = 0; low_at = -1;
    for (int k = 0; k < BUDGET && low_at < 0; k++) begin
      #3;
      if (ramREN && ramaddr == 32'h40) g++;
      if (!iwait) low_at = g;
      else @(negedge CLK);
    end
    check("ignt_cycles", 32'(g), 32'd3);
    check("iwait_low_cycle", 32'(low_at), 32'd3);
    @(negedge CLK);
    #3;
    check("ignt_released", 32'(ramREN), 32'd0);
    iREN = 1'b0;
    wait_i_done("t1_i_done");
    @(negedge CLK);

    // Simultaneous requests: data first, then instruction.
    fixed_lat = 1;
    comp_log.delete();
    i_start(32'h44);
    d_start(1'b0, 32'h180, 32'h0);
    wait_d_done("t2_d_done");
    dREN = 1'b0; dWEN = 1'b0;
    wait_i_done("t2_i_done");
    iREN = 1'b0;
    first  = (comp_log.size() > 0) ? comp_log[0] : -1;
    second = (comp_log.size() > 1) ? comp_log[1] : -1;
    check("t2_first_data", 32'(first), 32'd1);
    check("t2_second_instr", 32'(second), 32'd0);
    @(negedge CLK);

    // Read+write together is a write; read it back.
    d_start(1'b1, 32'h100, 32'hDEAD_BEEF);
    dREN = 1'b1;
    wait_d_done("t3_w_done");
    d_start(1'b0, 32'h100, 32'h0);
    wait_d_done("t3_r_done");
    dREN = 1'b0;
    @(negedge CLK);

    // Back-to-back stores against a held fetch request.
    d_since_i = 0;
    exp_run   = int'(LIMIT);
    fork
      begin
        for (int n = 0; n < 12; n++) begin
          d_start(1'b1, 32'h100 + 32'(4 * (n % 16)), $urandom);
          wait_d_done("t4_d_done");
        end
        dWEN = 1'b0; dREN = 1'b0;
      end
      begin
        for (int n = 0; n < 3; n++) begin
          i_start(32'h48 + 32'(4 * n));
          wait_i_done("t4_i_done");
        end
        iREN = 1'b0;
      end
    join
    exp_run = -1;
    @(negedge CLK);

    // RAM error during a fetch: sticky flag, wait held, retried.
    fixed_lat = 0;
    force_err = 1'b1;
    i_start(32'h4C);
    @(negedge CLK);
    #3;
    check("t5_iwait_on_error", 32'(iwait), 32'd1);
    @(negedge CLK);
    #3;
    check("t5_bus_err_set", 32'(bus_err), 32'd1);
    check("t5_idle_after_error", 32'(ramREN), 32'd0);
    wait_i_done("t5_retry_done");
    iREN = 1'b0;
    @(negedge CLK);
    #3;
    check("t5_bus_err_sticky", 32'(bus_err), 32'd1);
    @(negedge CLK);

    // Data read dropped before ACCESS: aborted, never completes.
    fixed_lat = 3;
    dREN = 1'b1; dWEN = 1'b0; daddr = 32'h1A0;
    @(negedge CLK);
    #3;
    check("t6_granted", 32'(ramREN), 32'd1);
    @(negedge CLK);
    dREN = 1'b0;
    #3;
    check("t6_abort_strobe", 32'(ramREN | ramWEN), 32'd0);
    repeat (3) begin
      @(negedge CLK);
      #3;
      check("t6_dwait_held", 32'(dwait), 32'd1);
    end
    @(negedge CLK);
    i_start(32'h50);
    wait_i_done("t6_fetch_after_abort");
    iREN = 1'b0;
    @(negedge CLK);

    // Reset in the middle of a data grant.
    dREN = 1'b1; daddr = 32'h1B0;
    @(negedge CLK);
    #3;
    check("t7_granted", 32'(ramREN), 32'd1);
    nRST = 1'b0;
    dREN = 1'b0;
    exp_bus_err = 1'b0;
    #1;
    check("t7_rst_strobe", 32'(ramREN | ramWEN), 32'd0);
    check("t7_rst_ramaddr", ramaddr, 32'd0);
    check("t7_rst_bus_err", 32'(bus_err), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      #3;
      check("t7_no_pulse", 32'(dwait), 32'd1);
    end
    @(negedge CLK);

    // Randomized mixed traffic with occasional RAM errors.
    fixed_lat = -1;
    err_pct   = 5;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          int gap;
          gap = int'($urandom_range(0, 3));
          if (gap > 0) begin
            dREN = 1'b0; dWEN = 1'b0;
            repeat (gap) @(negedge CLK);
          end
          d_start(1'($urandom_range(0, 1)), 32'h100 + 32'(4 * $urandom_range(0, 15)), $urandom);
          wait_d_done("rnd_d_done");
        end
        dREN = 1'b0; dWEN = 1'b0;
      end
      begin
        for (int n = 0; n < 30; n++) begin
          int gap;
          gap = int'($urandom_range(0, 3));
          if (gap > 0) begin
            iREN = 1'b0;
            repeat (gap) @(negedge CLK);
          end
          i_start(32'(4 * $urandom_range(0, 63)));
          wait_i_done("rnd_i_done");
        end
        iREN = 1'b0;
      end
    join
    err_pct = 0;
    repeat (3) @(negedge CLK);
    #3;
    check("final_bus_err", 32'(bus_err), 32'(exp_bus_err));
    check("final_idle", 32'(ramREN | ramWEN), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
